// File: rtl/comparator_pkg.sv
// Shared types and sizes for the 2-bit comparator self-test engine.
package comparator_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int ERR_W       = 5;
  localparam int CNT_W       = 4;
endpackage

// File: rtl/comparator_2bit_ref.sv
// Golden 2-bit magnitude comparator: x = A>B, y = A==B, z = A<B (purely combinational).
module comparator_2bit_ref (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic       o_x,
  output logic       o_y,
  output logic       o_z
);
  assign o_x = (i_a >  i_b);
  assign o_y = (i_a == i_b);
  assign o_z = (i_a <  i_b);
endmodule

// File: rtl/comparator_bist_checker.sv
// Sweeps all 16 A/B vectors into the comparator, checks x/y/z after SETTLE_CYCLES, reports results.
// COMPARATOR_BIST_STOP_ON_FAIL_EN: when defined, the sweep halts at the first mismatching vector.
module comparator_bist_checker
  import comparator_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_x,
  input  logic             dut_y,
  input  logic             dut_z,
  output logic             a1,
  output logic             a0,
  output logic             b1,
  output logic             b0,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_fail,
  output logic             fail_seen
);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [ERR_W-1:0] r_err;
  logic [IDX_W-1:0] r_first;
  logic             r_fail_seen;

  logic w_exp_x, w_exp_y, w_exp_z;
  logic w_mismatch;
  logic w_start_ok;
  logic w_last;

  comparator_2bit_ref u_ref (
    .i_a (r_idx[3:2]),
    .i_b (r_idx[1:0]),
    .o_x (w_exp_x),
    .o_y (w_exp_y),
    .o_z (w_exp_z)
  );

  assign w_mismatch = ({dut_x, dut_y, dut_z} != {w_exp_x, w_exp_y, w_exp_z});
  assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
  assign w_last     = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (w_start_ok) w_next = WAIT;
      WAIT:       if (r_cnt == '0) w_next = CHECK;
      CHECK: begin
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
        if (w_mismatch || w_last) w_next = DONE;
        else                      w_next = WAIT;
`else
        if (w_last) w_next = DONE;
        else        w_next = WAIT;
`endif
      end
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == WAIT) || (r_state == CHECK);
    done = (r_state == DONE);
    pass = (r_state == DONE) && !r_fail_seen;
  end

  // The index only advances when another vector follows, so DONE holds the last vector checked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_err       <= '0;
      r_first     <= '0;
      r_fail_seen <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_idx       <= '0;
            r_cnt       <= SETTLE_LOAD;
            r_err       <= '0;
            r_first     <= '0;
            r_fail_seen <= 1'b0;
          end
        end
        WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        CHECK: begin
          if (w_mismatch) begin
            r_err <= r_err + 1'b1;
            if (!r_fail_seen) begin
              r_first     <= r_idx;
              r_fail_seen <= 1'b1;
            end
          end
          if (w_next == WAIT) begin
            r_idx <= r_idx + 1'b1;
            r_cnt <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign {a1, a0, b1, b0} = r_idx;
  assign err_count        = r_err;
  assign first_fail       = r_first;
  assign fail_seen        = r_fail_seen;
endmodule

// File: tb/tb_comparator_bist_checker.sv
// Bench: a behavioural comparator with injectable faults, swept by the BIST and scored by a reference model.
module tb_comparator_bist_checker;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_x, dut_y, dut_z;
  logic       a1, a0, b1, b0;
  logic       busy, done, pass, fail_seen;
  logic [4:0] err_count;
  logic [3:0] first_fail;

  int total = 0;
  int bad   = 0;

  // 0 = correct, 1 = z stuck at 0, 2 = x/y swapped, 3 = per-vector random xor mask
  int         fault_mode = 0;
  logic [2:0] mask [16];
  logic [3:0] v;
  logic [1:0] ga, gb;
  logic [2:0] g;

  comparator_bist_checker #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dut_x      (dut_x),
    .dut_y      (dut_y),
    .dut_z      (dut_z),
    .a1         (a1),
    .a0         (a0),
    .b1         (b1),
    .b0         (b0),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail),
    .fail_seen  (fail_seen)
  );

  always #5 clk = ~clk;

  always_comb begin
    v  = {a1, a0, b1, b0};
    ga = v[3:2];
    gb = v[1:0];
    g  = {ga > gb, ga == gb, ga < gb};
    case (fault_mode)
      1:       g = {g[2], g[1], 1'b0};
      2:       g = {g[1], g[2], g[0]};
      3:       g = g ^ mask[v];
      default: ;
    endcase
    {dut_x, dut_y, dut_z} = g;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Which vectors the faulty comparator gets wrong, stated per fault rather than per bit.
  function automatic bit vec_bad(input int mode, input int a, input int b);
    case (mode)
      1:       return a < b;
      2:       return a >= b;
      3:       return mask[a * 4 + b] != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_sweep(input int mode, input string tag, input bit restart_pulses);
    int n_bad, first, cyc, exp_cycles, exp_err, exp_ops;
    n_bad = 0;
    first = -1;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        if (vec_bad(mode, a, b)) begin
          n_bad++;
          if (first < 0) first = a * 4 + b;
        end
`ifdef COMPARATOR_BIST_STOP_ON_FAIL_EN
    exp_cycles = (n_bad > 0) ? (first + 1) * (S + 1) : 16 * (S + 1);
    exp_err    = (n_bad > 0) ? 1 : 0;
    exp_ops    = (n_bad > 0) ? first : 15;
`else
    exp_cycles = 16 * (S + 1);
    exp_err    = n_bad;
    exp_ops    = 15;
`endif
    if (first < 0) first = 0;

    fault_mode = mode;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    check({tag, ".busy_at_start"}, 32'(busy), 1);
    check({tag, ".done_at_start"}, 32'(done), 0);
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = restart_pulses && (cyc == 5 || cyc == 30);
    end
    start = 1'b0;
    check({tag, ".cycles"},     32'(cyc),        32'(exp_cycles));
    check({tag, ".done"},       32'(done),       1);
    check({tag, ".busy"},       32'(busy),       0);
    check({tag, ".pass"},       32'(pass),       32'(n_bad == 0));
    check({tag, ".err_count"},  32'(err_count),  32'(exp_err));
    check({tag, ".first_fail"}, 32'(first_fail), 32'(first));
    check({tag, ".fail_seen"},  32'(fail_seen),  32'(n_bad > 0));
    check({tag, ".operands"},   32'({a1, a0, b1, b0}), 32'(exp_ops));
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},       32'(busy),       0);
    check({tag, ".done"},       32'(done),       0);
    check({tag, ".pass"},       32'(pass),       0);
    check({tag, ".err_count"},  32'(err_count),  0);
    check({tag, ".first_fail"}, 32'(first_fail), 0);
    check({tag, ".fail_seen"},  32'(fail_seen),  0);
    check({tag, ".operands"},   32'({a1, a0, b1, b0}), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) mask[i] = 3'b000;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle_after_reset");

    do_sweep(0, "good", 1'b0);
    do_sweep(1, "z_stuck0", 1'b0);
    do_sweep(2, "xy_swap", 1'b0);

    // Reset mid-sweep discards everything; a fresh sweep then behaves normally.
    fault_mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("mid_reset");
    do_sweep(0, "after_reset", 1'b0);

    do_sweep(2, "restart_ignored", 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++)
        mask[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      do_sweep(3, $sformatf("random%0d", r), 1'b0);
    end

    do_sweep(0, "good_again", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/comparator_bist_checker.md
# comparator_bist_checker

Self-test engine for the 2-bit magnitude comparator. It drives the comparator's four input bits through all 16 A/B combinations and samples the comparator's x/y/z outputs after a settle window. Each response is checked against a built-in golden model, and the block reports error count, first failing vector and pass/fail. It sits beside the comparator in the design and replaces hand-written stimulus for bring-up and on-board checks.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: cycles between applying a vector and sampling the DUT; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled in IDLE or DONE only
- dut_x  input  1  DUT output, A > B
- dut_y  input  1  DUT output, A == B
- dut_z  input  1  DUT output, A < B
- a1, a0  output  1 each  operand A to DUT, registered
- b1, b0  output  1 each  operand B to DUT, registered
- busy  output  1  sweep in progress
- done  output  1  sweep finished; held until next start or rst
- pass  output  1  done with zero errors; valid only while done=1
- err_count  output  5  mismatching vectors, 0..16
- first_fail  output  4  vector index of first mismatch; 0 if none
- fail_seen  output  1  at least one mismatch this sweep

## Operation
- Vector index idx, 4 bits; {a1,a0,b1,b0} = idx, so A = idx[3:2] and B = idx[1:0].
- Expected response: x = (A>B), y = (A==B), z = (A<B). Exactly one of x/y/z is high.
- A mismatch is any difference on x, y or z for that vector. Each mismatching vector adds 1 to err_count, however many bits differ.
- States:
  - IDLE: waiting for start.
  - WAIT: settle counter running.
  - CHECK: compare DUT response to expected.
  - DONE: results held.
- Transitions:
  - IDLE/DONE with start=1 → WAIT. This clears idx, err_count, first_fail and fail_seen, loads the settle counter with SETTLE_CYCLES-1, and drops done.
  - WAIT with counter=0 → CHECK; otherwise the counter decrements.
  - CHECK with idx=15 → DONE.
  - CHECK with idx<15 → WAIT, with idx+1 and the counter reloaded.
- On the first mismatch: first_fail ← idx and fail_seen ← 1. Later mismatches do not change first_fail.
- start while busy is ignored.
- rst, at any time including mid-sweep, returns the block to IDLE with every output at its reset value. No partial results are retained.
- Reset values: a1=a0=b1=b0=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_seen=0.

## Timing
- Operand outputs change on the clock edge that enters WAIT. The DUT is sampled in CHECK, exactly SETTLE_CYCLES cycles later.
- Each vector takes SETTLE_CYCLES+1 cycles.
- A full sweep runs 16×(SETTLE_CYCLES+1) cycles, from the edge that samples start to the edge that asserts done.
- busy=1 in WAIT and CHECK.
- done and pass assert on the same edge.
- err_count and first_fail update on the CHECK edge; they are visible the cycle after CHECK.
- The DUT is combinational. dut_* inputs are sampled directly with no synchronizer, since they share one clock domain.

## Configuration
- COMPARATOR_BIST_STOP_ON_FAIL_EN defined: CHECK with a mismatch goes straight to DONE. Then err_count=1, pass=0, and first_fail is the failing index. Operands hold the failing vector while in DONE.
- COMPARATOR_BIST_STOP_ON_FAIL_EN undefined: the full 16-vector sweep always runs. Operands hold vector 15 while in DONE.

## Structure
- Package comparator_pkg holds:
  - state enum: IDLE, WAIT, CHECK, DONE, 2-bit encoding;
  - NUM_VECTORS = 16;
  - IDX_W = 4;
  - ERR_W = 5.
- Sub-module comparator_2bit_ref: combinational golden model (A, B → x, y, z). It is instantiated once and fed from idx.
- The FSM, counters and result registers stay in the top module.

## Test plan
- Correct DUT (comparator_2bit_ref in loopback), SETTLE_CYCLES=2, one start pulse → after 48 cycles done=1, pass=1, err_count=0, fail_seen=0.
- DUT with z stuck at 0 → done=1, pass=0, err_count=6, first_fail=1 (A=0, B=1).
- DUT with x and y swapped → err_count=10 (6 A>B cases plus 4 equal cases), first_fail=0.
- rst asserted at cycle 20 of a sweep → next cycle IDLE, all outputs 0. A new start then completes the normal 48-cycle sweep.
- start pulsed again at cycles 5 and 30 of a sweep → ignored; done still arrives at cycle 48 and err_count is unaffected.
- COMPARATOR_BIST_STOP_ON_FAIL_EN defined, z stuck at 0 → done after 6 cycles, err_count=1, first_fail=1, operands {a1,a0,b1,b0}=0001.
